// File: rtl/led_level_pwm_pkg.sv
// led_pkg
// Constants and types shared by the nibble-to-level decoder and the LED PWM
// brightness driver. Level codes are LEVEL_W bits wide; only LEVEL_MIN..LEVEL_MAX
// are meaningful brightness values, and the PWM period has PWM_PHASES steps.
package led_pkg;

   localparam int LEVEL_W    = 8;
   localparam int PWM_PHASES = 16;
   localparam int PHASE_W    = 4;

   // The active level must hold the value 16, so it is one bit wider than the phase.
   localparam int ACTIVE_W   = PHASE_W + 1;

   localparam logic [LEVEL_W-1:0] LEVEL_MIN = LEVEL_W'(1);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(16);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PWM_PHASES - 1);

   typedef logic [LEVEL_W-1:0]  level_t;
   typedef logic [PHASE_W-1:0]  phase_t;
   typedef logic [ACTIVE_W-1:0] active_t;

   // True when a decoder code is a usable brightness level.
   function automatic logic level_valid(input level_t code);
      return (code >= LEVEL_MIN) && (code <= LEVEL_MAX);
   endfunction

endpackage

// File: rtl/led_level_pwm_if.sv
// led_level_pwm_if
// Groups the level-code input, the error clear and the PWM-side outputs of the
// LED brightness driver.
//   level        : level code from the decoder (valid 1..16)
//   err_clr      : single-cycle clear for level_err
//   pwm_out      : registered PWM waveform
//   period_start : one-cycle pulse on the first cycle of each PWM period
//   level_err    : sticky invalid-code flag
// master drives level/err_clr (decoder or bench), slave is the PWM driver.
interface led_level_pwm_if;
   import led_pkg::*;

   level_t level;
   logic   err_clr;
   logic   pwm_out;
   logic   period_start;
   logic   level_err;

   modport master (
      output level,
      output err_clr,
      input  pwm_out,
      input  period_start,
      input  level_err
   );

   modport slave (
      input  level,
      input  err_clr,
      output pwm_out,
      output period_start,
      output level_err
   );

endinterface

// File: rtl/led_level_pwm_prescaler.sv
// pwm_prescaler
// Divides clk into PWM phase steps: tick is high on the last cycle of every
// PRESCALE-cycle step.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : counting enable; the counter holds while low
//   tick : high while the counter sits on its terminal value (PRESCALE-1)
module pwm_prescaler #(
   parameter int PRESCALE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   // A PRESCALE of 1 still gets a 1-bit counter; it simply never leaves 0.
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre;

   assign tick = (pre == PRE_LAST);

   // Free-running modulo-PRESCALE counter, frozen at 0 until the driver has
   // loaded its first level so the first period starts cleanly aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
      end else if (en) begin
         if (tick) begin
            pre <= '0;
         end else begin
            pre <= pre + 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_level_pwm.sv
// led_level_pwm
// LED brightness driver: turns a decoder level code (1..16) into a 16-step PWM
// waveform. New codes are only taken at period boundaries so the waveform never
// glitches mid-period; invalid codes leave the current level in place and set
// a sticky error flag.
//   PRESCALE : clk cycles per PWM phase step (>= 1)
//   clk      : system clock
//   rst      : synchronous active-high reset
//   bus      : led_level_pwm_if slave (level, err_clr in; pwm_out,
//              period_start, level_err out, all outputs registered)
module led_level_pwm
   import led_pkg::*;
#(
   parameter int PRESCALE = 16
) (
   input  logic            clk,
   input  logic            rst,
   led_level_pwm_if.slave  bus
);

   phase_t  phase;
   phase_t  phase_next;
   active_t active;
   active_t active_next;
   logic    loaded;
   logic    tick;
   logic    load_now;
   logic    level_ok;

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (loaded),
      .tick (tick)
   );

   assign level_ok = level_valid(bus.level);

   // A load happens on the first edge out of reset and then on the last
   // cycle of every period, which makes the following cycle a period start.
   assign load_now = !loaded || (tick && (phase == PHASE_LAST));

   // Post-edge phase and level; the output compare uses these so pwm_out
   // lines up with the phase register rather than lagging it by a cycle.
   always_comb begin
      phase_next  = phase;
      active_next = active;
      if (loaded && tick) begin
         phase_next = phase + 1'b1;
      end
      if (load_now && level_ok) begin
         active_next = bus.level[ACTIVE_W-1:0];
      end
   end

   // Main state update. The error flag gives an invalid load priority over a
   // simultaneous clear so an error can never be silently lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase            <= '0;
         active           <= '0;
         loaded           <= 1'b0;
         bus.pwm_out      <= 1'b0;
         bus.period_start <= 1'b0;
         bus.level_err    <= 1'b0;
      end else begin
         loaded           <= 1'b1;
         phase            <= phase_next;
         active           <= active_next;
         bus.pwm_out      <= ({1'b0, phase_next} < active_next);
         bus.period_start <= load_now;
         if (load_now && !level_ok) begin
            bus.level_err <= 1'b1;
         end else if (bus.err_clr) begin
            bus.level_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_led_level_pwm.sv
// tb_led_level_pwm
// Scoreboard bench for led_level_pwm. Two instances are used: PRESCALE=4 for
// most scenarios and PRESCALE=1 for the degenerate prescaler. Each stimulus
// step pushes the hand-derived outputs expected for the cycle after its edge;
// a monitor on the falling edge pops and compares them.
module tb_led_level_pwm;
   import led_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   led_level_pwm_if busA ();
   led_level_pwm_if busB ();

   led_level_pwm #(.PRESCALE(4)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA)
   );

   led_level_pwm #(.PRESCALE(1)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit   dut;
      int   tag;
      logic pwm;
      logic ps;
      logic err;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   step     = 0;

   // One comparison; every mismatch is reported and counted.
   task automatic checkOutput(input string name, input int tag, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s step=%0d actual=%0b required=%0b", name, tag, act, req);
      end
   endtask

   // Monitor: drains everything the stimulus side has queued for this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut) begin
               checkOutput("B.pwm_out",      e.tag, busB.pwm_out,      e.pwm);
               checkOutput("B.period_start", e.tag, busB.period_start, e.ps);
               checkOutput("B.level_err",    e.tag, busB.level_err,    e.err);
            end else begin
               checkOutput("A.pwm_out",      e.tag, busA.pwm_out,      e.pwm);
               checkOutput("A.period_start", e.tag, busA.period_start, e.ps);
               checkOutput("A.level_err",    e.tag, busA.level_err,    e.err);
            end
         end
      end
   end

   // Drive inputs for the next edge, then queue what that edge must produce.
   task automatic applyStimulus(input bit dut, input logic r, input logic [7:0] lvl,
                                input logic clr, input logic ep, input logic eps,
                                input logic eerr);
      exp_t e;
      if (dut) begin
         busB.level   = lvl;
         busB.err_clr = clr;
      end else begin
         busA.level   = lvl;
         busA.err_clr = clr;
      end
      rst = r;
      @(posedge clk);
      #1;
      e.dut = dut;
      e.tag = step;
      e.pwm = ep;
      e.ps  = eps;
      e.err = eerr;
      sb.push_back(e);
      step++;
   endtask

   task automatic resetStep(input bit dut);
      applyStimulus(dut, 1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Runs ncyc steps of one period. Step 0's edge is the boundary load, so
   // lvlA at k=0 decides this period's level; expL is the level expected to
   // be active. err_clr pulses at step clrK; level_err is errStart before it
   // and errAfter from it on.
   task automatic runPeriod(input bit dut, input int pre, input logic [7:0] lvlA,
                            input logic [7:0] lvlB, input int switchK, input int expL,
                            input logic errStart, input int clrK, input logic errAfter,
                            input int ncyc);
      logic [7:0] lv;
      logic       ee;
      for (int k = 0; k < ncyc; k++) begin
         lv = (k < switchK) ? lvlA : lvlB;
         ee = (clrK >= 0 && k >= clrK) ? errAfter : errStart;
         applyStimulus(dut, 1'b0, lv, (k == clrK), (k < expL * pre), (k == 0), ee);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      busA.level   = 8'd8;
      busA.err_clr = 1'b0;
      busB.level   = 8'd5;
      busB.err_clr = 1'b0;

      // PRESCALE=4: reset, then level 8 held for two periods.
      resetStep(0);
      resetStep(0);
      runPeriod(0, 4, 8'd8, 8'd8, 64, 8, 1'b0, -1, 1'b0, 64);
      runPeriod(0, 4, 8'd8, 8'd8, 64, 8, 1'b0, -1, 1'b0, 64);

      // 8 -> 3 at cycle 10: this period stays at 8, the next one is 3.
      runPeriod(0, 4, 8'd8, 8'd3, 10, 8, 1'b0, -1, 1'b0, 64);
      runPeriod(0, 4, 8'd3, 8'd3, 64, 3, 1'b0, -1, 1'b0, 64);

      // Full brightness, then minimum brightness.
      runPeriod(0, 4, 8'd16, 8'd16, 64, 16, 1'b0, -1, 1'b0, 64);
      runPeriod(0, 4, 8'd16, 8'd16, 64, 16, 1'b0, -1, 1'b0, 64);
      runPeriod(0, 4, 8'd1, 8'd1, 64, 1, 1'b0, -1, 1'b0, 64);

      // 17 at a boundary keeps level 1 and raises the error.
      runPeriod(0, 4, 8'd17, 8'd17, 64, 1, 1'b1, -1, 1'b1, 64);
      // Plain clear mid-period.
      runPeriod(0, 4, 8'd8, 8'd8, 64, 8, 1'b1, 5, 1'b0, 64);
      // Clear on the same edge as an invalid load: the set wins.
      runPeriod(0, 4, 8'd200, 8'd8, 1, 8, 1'b1, 0, 1'b1, 64);
      runPeriod(0, 4, 8'd8, 8'd8, 64, 8, 1'b1, 3, 1'b0, 64);

      // Invalid 0 at a boundary, then reset inside the high portion.
      runPeriod(0, 4, 8'd0, 8'd8, 1, 8, 1'b1, -1, 1'b1, 10);
      resetStep(0);
      runPeriod(0, 4, 8'd5, 8'd5, 64, 5, 1'b0, -1, 1'b0, 64);
      runPeriod(0, 4, 8'd5, 8'd5, 64, 5, 1'b0, -1, 1'b0, 64);

      // Level 0 at E0: nothing loaded, output stays low, error set.
      resetStep(0);
      runPeriod(0, 4, 8'd0, 8'd0, 64, 0, 1'b1, -1, 1'b1, 64);
      runPeriod(0, 4, 8'd17, 8'd17, 64, 0, 1'b1, -1, 1'b1, 64);
      runPeriod(0, 4, 8'd6, 8'd6, 64, 6, 1'b1, 0, 1'b0, 64);

      // PRESCALE=1, level 5: 16-cycle periods with 5 high cycles.
      resetStep(1);
      runPeriod(1, 1, 8'd5, 8'd5, 16, 5, 1'b0, -1, 1'b0, 16);
      runPeriod(1, 1, 8'd5, 8'd5, 16, 5, 1'b0, -1, 1'b0, 16);
      runPeriod(1, 1, 8'd5, 8'd5, 16, 5, 1'b0, -1, 1'b0, 16);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_level_pwm.md
# led_level_pwm

Brightness driver for the Nunchuck LED path. It consumes the 8-bit level code produced by the nibble-to-level decoder (valid codes 1..16) and turns it into a 16-step PWM waveform on a single LED pin. New level codes are taken only at PWM period boundaries, so a level change never produces a glitch mid-period. Invalid codes are rejected and reported through a sticky error flag.

## Interface

- `PRESCALE`, default 16: clk cycles per PWM phase step. Must be ≥1; a PWM period is 16×PRESCALE cycles.
- `clk`  in  1  system clock. All logic runs on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `level`  in  8  level code from the decoder. 1..16 are valid; 0 and 17..255 are invalid.
- `err_clr`  in  1  single-cycle clear for `level_err`.
- `pwm_out`  out  1  PWM output, registered.
- `period_start`  out  1  one-cycle pulse on the first cycle of each PWM period, registered.
- `level_err`  out  1  sticky flag set when an invalid code is sampled, registered.

## Operation

- State:
  - prescaler `pre` (0..PRESCALE-1)
  - phase counter `phase` [3:0]
  - active level `active` [4:0]
  - `loaded` flag
- Reset values: `pre`=0, `phase`=0, `active`=0, `loaded`=0, `pwm_out`=0, `period_start`=0, `level_err`=0.
- Definitions:
  - `tick` = (`pre`==PRESCALE-1).
  - `load_now` = !`loaded` OR (`tick` AND `phase`==15).
- While `loaded`=0:
  - `pre` and `phase` hold at 0.
  - `loaded` sets on the first edge with `rst`=0.
- While `loaded`=1:
  - `pre` increments and wraps to 0 on `tick`.
  - `phase` increments on `tick`, wrapping 15→0.
- On `load_now`:
  - If `level` is in 1..16, `active` ← `level`[4:0].
  - Otherwise `active` holds and `level_err` ← 1.
- Changes on `level` outside load edges are ignored.
- `pwm_out` ← (phase' < active'), where phase' and active' are the post-edge values. So `pwm_out` is high exactly while the phase register is below `active`.
  - Level L gives L×PRESCALE high cycles per period, contiguous from the period start.
  - Level 16 gives a constant high.
  - `active`=0 (no valid code loaded yet) gives a constant low.
- `period_start` ← `load_now`. It is high for one cycle, coinciding with `phase`=0 and `pre`=0.
- `level_err` clear and set:
  - `err_clr` clears `level_err` on the next edge.
  - If an invalid load happens on the same edge, the set wins.
- `rst` asserted mid-operation: all state returns to reset values on that edge. `pwm_out` is low on the following cycle, and a fresh load occurs on the first edge after release.

## Timing

- First edge after reset release (E0):
  - `active` loads.
  - `period_start`=1 and `pwm_out`=(0<`active`) in the cycle after E0.
  - The period then lasts exactly 16×PRESCALE cycles.
- Level-change latency: a new code present at the boundary edge is visible on `pwm_out` in the first cycle of the next period. The worst case is 16×PRESCALE cycles.
- The output is registered, with no combinational path from `level` to `pwm_out`.
- PRESCALE=1: `tick` is always 1, `pre` is a constant 0 (a 1-bit register is acceptable), and the period is 16 cycles.
- Prescaler width is clog2(PRESCALE), minimum 1 bit.
- The level compare is 5-bit: `phase` zero-extended against `active`.

## Structure

- Shared package `led_pkg` holds:
  - `LEVEL_W`=8
  - `LEVEL_MIN`=1
  - `LEVEL_MAX`=16
  - `PWM_PHASES`=16
  - `PHASE_W`=4
- The decoder and this block share these constants.
- One sub-module, `pwm_prescaler` (parameter PRESCALE; ports `clk`, `rst`, `en`, `tick`), holds the `pre` counter. The top level holds phase, load and compare logic.

## Test plan

- PRESCALE=4, `level`=8 held: `period_start` pulses every 64 cycles; `pwm_out` is high for 32 consecutive cycles starting on each `period_start` cycle, then low for 32.
- PRESCALE=4:
  - `level`=16 gives `pwm_out` constantly 1 after E0.
  - `level`=1 gives 4 high and 60 low cycles per period.
- PRESCALE=4, `level` 8→3 at cycle 10 of a period: the current period still has 32 high cycles; the next period has 12 high cycles.
- Invalid code handling:
  - `level`=0 at E0 gives `active`=0, `pwm_out` low, and `level_err`=1.
  - A later boundary with `level`=17 holds the previous `active` and keeps `level_err`=1.
  - `err_clr` alone clears `level_err`; `err_clr` on the same edge as an invalid load leaves it at 1.
- `rst` pulsed during the high portion: the next cycle has `pwm_out`=0, `period_start`=0 and `level_err`=0. After release, `period_start` fires one cycle after E0 and a full 64-cycle period follows.
- PRESCALE=1, `level`=5: 16-cycle period, `pwm_out` high for 5 cycles, `period_start` every 16 cycles.
